demod_scheduler: RTL and testbench

DEMOD_SCHEDULER -- requirements
Module: demod_scheduler

---
 rtl/demod_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_demod_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demod_scheduler.sv
// demod_scheduler: shares one magnitude engine among four I/Q channels using round-robin
// grants. It holds one sample per channel, reports overrun per channel and detects engine timeouts.

module demod_sched_lane #(
    parameter int BITS = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            load_i,
    input  logic            gnt_i,
    input  logic [BITS-1:0] i_i,
    input  logic [BITS-1:0] q_i,
    output logic [BITS-1:0] hold_i_o,
    output logic [BITS-1:0] hold_q_o,
    output logic            pend_o,
    output logic            ovr_set_o
);
    logic [BITS-1:0] hi_q, hq_q;
    logic            pend_q, pend_d;

    // A tick on the grant edge keeps the channel pending, so the new sample still goes out.
    assign pend_d    = load_i | (pend_q & ~gnt_i);
    assign ovr_set_o = load_i & pend_q & ~gnt_i;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hi_q   <= '0;
            hq_q   <= '0;
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (load_i) begin
                hi_q <= i_i;
                hq_q <= q_i;
            end
        end
    end

    assign hold_i_o = hi_q;
    assign hold_q_o = hq_q;
    assign pend_o   = pend_q;
endmodule

module demod_scheduler #(
    parameter int BITS    = 16,
    parameter int TIMEOUT = 63
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [4*BITS-1:0] ch_I_in,
    input  logic [4*BITS-1:0] ch_Q_in,
    input  logic [3:0]        ch_load_tick,
    output logic [BITS-1:0]   eng_I,
    output logic [BITS-1:0]   eng_Q,
    output logic              eng_load_tick,
    input  logic [BITS-1:0]   eng_demod_in,
    input  logic              eng_out_tick,
    output logic [BITS-1:0]   demod_out,
    output logic [1:0]        demod_ch,
    output logic              out_tick,
    output logic [3:0]        overrun,
    output logic              timeout_err,
    input  logic              clr_err
);
    localparam int NCH = 4;
    localparam int CW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 last_q, last_d, gnt_q, gnt_d, sel, cand;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [BITS-1:0]            eng_i_q, eng_i_d, eng_q_q, eng_q_d;
    logic [BITS-1:0]            dout_q, dout_d;
    logic [1:0]                 dch_q, dch_d;
    logic                       eng_ld_q, eng_ld_d, otick_q, otick_d;
    logic [3:0]                 ovr_q, ovr_d;
    logic                       terr_q, terr_d, terr_set;
    logic                       grant_fire, found;
    logic [NCH-1:0]             pend, ovr_set, gnt_vec;
    logic [NCH-1:0][BITS-1:0]   hold_i, hold_q;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        demod_sched_lane #(.BITS(BITS)) u_lane (
            .CLK       (CLK),
            .RST       (RST),
            .load_i    (ch_load_tick[k]),
            .gnt_i     (gnt_vec[k]),
            .i_i       (ch_I_in[k*BITS +: BITS]),
            .q_i       (ch_Q_in[k*BITS +: BITS]),
            .hold_i_o  (hold_i[k]),
            .hold_q_o  (hold_q[k]),
            .pend_o    (pend[k]),
            .ovr_set_o (ovr_set[k])
        );
    end

    // Round-robin: first pending channel after last_grant, wrapping back to last_grant itself.
    always_comb begin
        sel   = last_q;
        cand  = '0;
        found = 1'b0;
        for (int o = 1; o <= NCH; o++) begin
            cand = last_q + 2'(o);
            if (!found && pend[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    assign grant_fire = (state_q == IDLE) && (|pend);

    always_comb begin
        gnt_vec = '0;
        if (grant_fire) gnt_vec[sel] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        eng_i_d  = eng_i_q;
        eng_q_d  = eng_q_q;
        eng_ld_d = 1'b0;
        dout_d   = dout_q;
        dch_d    = dch_q;
        otick_d  = 1'b0;
        terr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_fire) begin
                    state_d  = ISSUE;
                    gnt_d    = sel;
                    eng_i_d  = hold_i[sel];
                    eng_q_d  = hold_q[sel];
                    eng_ld_d = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (eng_out_tick) begin
                    dout_d  = eng_demod_in;
                    dch_d   = gnt_q;
                    otick_d = 1'b1;
                    last_d  = gnt_q;
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th silent WAIT cycle, so the job is dropped.
                    terr_set = 1'b1;
                    last_d   = gnt_q;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ovr_d  = (clr_err ? 4'b0 : ovr_q) | ovr_set;
        terr_d = (clr_err ? 1'b0 : terr_q) | terr_set;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            last_q   <= 2'd3;
            gnt_q    <= '0;
            cnt_q    <= '0;
            eng_i_q  <= '0;
            eng_q_q  <= '0;
            eng_ld_q <= 1'b0;
            dout_q   <= '0;
            dch_q    <= '0;
            otick_q  <= 1'b0;
            ovr_q    <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            eng_i_q  <= eng_i_d;
            eng_q_q  <= eng_q_d;
            eng_ld_q <= eng_ld_d;
            dout_q   <= dout_d;
            dch_q    <= dch_d;
            otick_q  <= otick_d;
            ovr_q    <= ovr_d;
            terr_q   <= terr_d;
        end
    end

    assign eng_I         = eng_i_q;
    assign eng_Q         = eng_q_q;
    assign eng_load_tick = eng_ld_q;
    assign demod_out     = dout_q;
    assign demod_ch      = dch_q;
    assign out_tick      = otick_q;
    assign overrun       = ovr_q;
    assign timeout_err   = terr_q;
endmodule

// File: tb/tb_demod_scheduler.sv
// Scoreboard bench for demod_scheduler: a per-cycle reference model queues the expected issues and results.
// A separate monitor pops and compares them, and an engine agent answers with randomized latency.
module tb_demod_scheduler;
    localparam int BITS    = 16;
    localparam int TIMEOUT = 63;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [4*BITS-1:0] ch_I_in = '0, ch_Q_in = '0;
    logic [3:0]        ch_load_tick = '0;
    logic [BITS-1:0]   eng_I, eng_Q, demod_out;
    logic [BITS-1:0]   eng_demod_in = '0;
    logic              eng_load_tick, out_tick, timeout_err;
    logic              eng_out_tick = 1'b0, clr_err = 1'b0;
    logic [1:0]        demod_ch;
    logic [3:0]        overrun;

    int checks = 0, failures = 0;

    always #5 CLK = ~CLK;

    demod_scheduler #(.BITS(BITS), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .ch_I_in(ch_I_in), .ch_Q_in(ch_Q_in),
        .ch_load_tick(ch_load_tick), .eng_I(eng_I), .eng_Q(eng_Q),
        .eng_load_tick(eng_load_tick), .eng_demod_in(eng_demod_in),
        .eng_out_tick(eng_out_tick), .demod_out(demod_out), .demod_ch(demod_ch),
        .out_tick(out_tick), .overrun(overrun), .timeout_err(timeout_err),
        .clr_err(clr_err)
    );

    typedef struct { logic [BITS-1:0] i; logic [BITS-1:0] q; } iss_t;
    typedef struct { logic [BITS-1:0] val; logic [1:0] ch; } res_t;
    iss_t iq[$];
    res_t oq[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model (mode: 0 idle, 1 issuing, 2 awaiting engine)
    int              m_mode = 0, m_last = 3, m_job = 0, m_cnt = 0;
    bit [3:0]        m_pend = '0, m_ovr = '0;
    bit              m_terr = 0, m_ld = 0, m_ot = 0;
    logic [BITS-1:0] m_hi[4], m_hq[4];
    logic [BITS-1:0] m_cur_i = '0, m_cur_q = '0;

    always @(posedge CLK or posedge RST) begin
        int g;
        if (RST) begin
            m_mode = 0; m_last = 3; m_job = 0; m_cnt = 0;
            m_pend = '0; m_ovr = '0; m_terr = 0; m_ld = 0; m_ot = 0;
            m_cur_i = '0; m_cur_q = '0;
            for (int k = 0; k < 4; k++) begin m_hi[k] = '0; m_hq[k] = '0; end
            iq.delete(); oq.delete();
        end else begin
            g = -1;
            if (m_mode == 0)
                for (int o = 1; o <= 4; o++)
                    if (g < 0 && m_pend[(m_last + o) % 4]) g = (m_last + o) % 4;
            m_ld = (g >= 0);
            m_ot = 0;
            if (clr_err) begin m_ovr = '0; m_terr = 0; end
            if (m_mode == 0) begin
                if (g >= 0) begin
                    m_cur_i = m_hi[g]; m_cur_q = m_hq[g];
                    iq.push_back('{m_hi[g], m_hq[g]});
                    m_job = g; m_pend[g] = 0; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                m_mode = 2; m_cnt = 0;
            end else begin
                if (eng_out_tick) begin
                    oq.push_back('{eng_demod_in, 2'(m_job)});
                    m_ot = 1; m_last = m_job; m_mode = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == TIMEOUT) begin m_terr = 1; m_last = m_job; m_mode = 0; end
                end
            end
            for (int k = 0; k < 4; k++)
                if (ch_load_tick[k]) begin
                    if (m_pend[k]) m_ovr[k] = 1;
                    m_pend[k] = 1;
                    m_hi[k] = ch_I_in[k*BITS +: BITS];
                    m_hq[k] = ch_Q_in[k*BITS +: BITS];
                end
        end
    end

    // Monitor
    int out_cnt = 0;
    always @(negedge CLK) begin
        chk("eng_load_tick", 64'(eng_load_tick), 64'(m_ld));
        chk("out_tick", 64'(out_tick), 64'(m_ot));
        chk("overrun", 64'(overrun), 64'(m_ovr));
        chk("timeout_err", 64'(timeout_err), 64'(m_terr));
        if (RST) begin
            chk("rst_eng_I", 64'(eng_I), 0);
            chk("rst_eng_Q", 64'(eng_Q), 0);
            chk("rst_demod_out", 64'(demod_out), 0);
            chk("rst_demod_ch", 64'(demod_ch), 0);
        end else if (m_mode != 0) begin
            chk("eng_I_held", 64'(eng_I), 64'(m_cur_i));
            chk("eng_Q_held", 64'(eng_Q), 64'(m_cur_q));
        end
        if (eng_load_tick) begin
            iss_t e;
            chk("issue_expected", 64'(iq.size() != 0), 1);
            if (iq.size() != 0) begin
                e = iq.pop_front();
                chk("issue_eng_I", 64'(eng_I), 64'(e.i));
                chk("issue_eng_Q", 64'(eng_Q), 64'(e.q));
            end
        end
        if (out_tick) begin
            res_t r;
            out_cnt++;
            chk("result_expected", 64'(oq.size() != 0), 1);
            if (oq.size() != 0) begin
                r = oq.pop_front();
                chk("demod_out", 64'(demod_out), 64'(r.val));
                chk("demod_ch", 64'(demod_ch), 64'(r.ch));
            end
        end
    end

    // Engine agent: mode 0 random latency, 1 fixed latency/value, 2 silent
    int              resp_mode = 1, resp_delay = 1, cd = 0;
    logic [BITS-1:0] resp_val = '0, resp_cur = '0;
    bit              spur_en = 0;
    always @(negedge CLK) begin
        eng_out_tick = 1'b0;
        if (eng_load_tick) begin
            case (resp_mode)
                0:       cd = $urandom_range(70, 1);
                1:       cd = resp_delay;
                default: cd = 0;
            endcase
            resp_cur = (resp_mode == 1) ? resp_val : (eng_I ^ eng_Q);
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin eng_out_tick = 1'b1; eng_demod_in = resp_cur; end
        end else if (spur_en && $urandom_range(39, 0) == 0) begin
            eng_out_tick = 1'b1;
            eng_demod_in = BITS'($urandom);
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_ch(int k, logic [BITS-1:0] i, logic [BITS-1:0] q);
        ch_I_in[k*BITS +: BITS] = i;
        ch_Q_in[k*BITS +: BITS] = q;
    endtask

    task automatic pulse(logic [3:0] m);
        @(negedge CLK); ch_load_tick = m;
        @(negedge CLK); ch_load_tick = '0;
    endtask

    task automatic do_reset(int n);
        @(posedge CLK); #2 RST = 1'b1;
        repeat (n) @(posedge CLK);
        #2 RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wait_idle(string name, int limit);
        int n = 0;
        while (!(m_mode == 0 && m_pend == 0 && cd == 0) && n < limit) begin
            @(negedge CLK); n++;
        end
        cyc(2);
        chk(name, 64'(n < limit), 1);
    endtask

    task automatic clear_errs();
        @(negedge CLK); clr_err = 1'b1;
        @(negedge CLK); clr_err = 1'b0;
    endtask

    initial begin
        int oc;
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int oc;
        cyc(3);
        chk("rst_overrun", 64'(overrun), 0);
        chk("rst_timeout_err", 64'(timeout_err), 0);
        chk("rst_eng_load_tick", 64'(eng_load_tick), 0);
        chk("rst_out_tick", 64'(out_tick), 0);
        @(posedge CLK); #2 RST = 1'b0;
        @(negedge CLK);

        // single job on ch1, engine answers 5 after 20 cycles
        resp_mode = 1; resp_delay = 20; resp_val = 5;
        set_ch(1, 3, 4);
        pulse(4'b0010);
        chk("latency_one_edge", 64'(eng_load_tick), 0);
        cyc(1);
        chk("latency_two_edges", 64'(eng_load_tick), 1);
        wait_idle("single_drain", 100);
        chk("single_demod_out", 64'(demod_out), 5);
        chk("single_demod_ch", 64'(demod_ch), 1);

        // fairness from reset, twice
        do_reset(2);
        resp_delay = 3;
        for (int k = 0; k < 4; k++) set_ch(k, BITS'(100 + k), BITS'(200 + k));
        pulse(4'hF);
        wait_idle("fair1_drain", 200);
        for (int k = 0; k < 4; k++) set_ch(k, BITS'(300 + k), BITS'(400 + k));
        pulse(4'hF);
        wait_idle("fair2_drain", 200);
        chk("fair_last_ch", 64'(demod_ch), 3);

        // overrun on ch2 while ch0 is busy
        resp_delay = 10;
        set_ch(0, 1, 1);   pulse(4'b0001);
        set_ch(2, 10, 0);  pulse(4'b0100);
        cyc(1);
        set_ch(2, 20, 0);  pulse(4'b0100);
        wait_idle("overrun_drain", 200);
        chk("overrun_flag", 64'(overrun), 64'(4'b0100));
        clear_errs();
        chk("overrun_cleared", 64'(overrun), 0);

        // engine silent: two jobs time out back to back
        resp_mode = 2;
        set_ch(3, 33, 3); pulse(4'b1000);
        set_ch(1, 11, 1); pulse(4'b0010);
        wait_idle("timeout_drain", 400);
        chk("timeout_flag", 64'(timeout_err), 1);
        clear_errs();
        chk("timeout_cleared", 64'(timeout_err), 0);

        // coincident tick on ch0's grant edge
        resp_mode = 1; resp_delay = 2;
        set_ch(0, 7, 1);
        @(negedge CLK); ch_load_tick = 4'b0001;
        @(negedge CLK); set_ch(0, 8, 2);
        @(negedge CLK); ch_load_tick = '0;
        wait_idle("coincide_drain", 100);
        chk("coincide_no_overrun", 64'(overrun), 0);
        chk("coincide_last_out", 64'(demod_ch), 0);

        // reset during WAIT, engine answers after release
        resp_delay = 30;
        set_ch(2, 55, 66); pulse(4'b0100);
        cyc(10);
        oc = out_cnt;
        do_reset(2);
        chk("midrst_eng_I", 64'(eng_I), 0);
        chk("midrst_demod_out", 64'(demod_out), 0);
        chk("midrst_overrun", 64'(overrun), 0);
        cyc(40);
        chk("late_result_ignored", 64'(out_cnt - oc), 0);

        // randomized traffic
        resp_mode = 0; spur_en = 1;
        for (int n = 0; n < 600; n++) begin
            @(negedge CLK);
            ch_I_in = {$urandom, $urandom};
            ch_Q_in = {$urandom, $urandom};
            ch_load_tick = 4'($urandom) & 4'($urandom) & 4'($urandom);
            clr_err = ($urandom_range(29, 0) == 0);
        end
        @(negedge CLK);
        ch_load_tick = '0; clr_err = 1'b0; spur_en = 0;
        wait_idle("random_drain", 2000);
        chk("issue_queue_empty", 64'(iq.size()), 0);
        chk("result_queue_empty", 64'(oq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
